dac_sample_sched: RTL and testbench

//  Schedules 4-bit sample updates from two sound sources into the shared 4-bit PWM DAC.

---
 rtl/dac_sample_sched.sv | 164 ++++++++++++++++
 tb/tb_dac_sample_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_sched.sv
// Two-source sample scheduler for the 4-bit PWM DAC: combinational req/ack into one-deep slots,
// at most one commit per frame (decided on frame_tick, visible next cycle), starvation guard and idle decay.
module dac_sample_sched #(
    parameter int FRAME_LEN   = 8192,
    parameter int STARVE_MAX  = 4,
    parameter int IDLE_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       req_a,
    input  logic [3:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [3:0] data_b,
    output logic       ack_b,
    input  logic       mute,
    output logic [3:0] dac_code,
    output logic       frame_tick,
    output logic [1:0] src_sel
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int IW = $clog2(IDLE_FRAMES + 1);
    localparam logic [CW-1:0] LP_CNT_LAST   = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LP_CNT_PRE    = CW'(FRAME_LEN - 2);
    localparam logic [SW-1:0] LP_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [IW-1:0] LP_IDLE_MAX   = IW'(IDLE_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD, ST_DECAY} state_t;

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic [3:0]    r_slot_a, r_slot_b;
    logic          r_full_a, r_full_b;
    logic          r_ack_a_q, r_ack_b_q;
    logic [SW-1:0] r_starve;
    logic [IW-1:0] r_idle;
    state_t        r_state;
    logic [3:0]    r_code;
    logic [1:0]    r_src;

    logic          w_ack_a, w_ack_b;
    logic          w_win_a, w_win_b;
    logic [IW-1:0] w_idle_inc;
    state_t        w_state_nxt;
    logic [3:0]    w_code_nxt;
    logic [1:0]    w_src_nxt;
    logic [IW-1:0] w_idle_nxt;
    logic [SW-1:0] w_starve_nxt;

    // Ack is combinational so data is captured in the pulse cycle; gated by reset so all
    // outputs read 0 while Reset_n is low. The registered ack enforces the one-cycle gap.
    assign w_ack_a = Reset_n & req_a & ~r_full_a & ~r_ack_a_q;
    assign w_ack_b = Reset_n & req_b & ~r_full_b & ~r_ack_b_q;

    assign w_win_b    = r_tick & r_full_b & (~r_full_a | (r_starve == LP_STARVE_MAX));
    assign w_win_a    = r_tick & r_full_a & ~w_win_b;
    assign w_idle_inc = (r_idle == LP_IDLE_MAX) ? r_idle : r_idle + 1'b1;

    assign ack_a      = w_ack_a;
    assign ack_b      = w_ack_b;
    assign dac_code   = r_code;
    assign frame_tick = r_tick;
    assign src_sel    = r_src;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LP_CNT_LAST) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == LP_CNT_PRE);
        end
    end

    // Slots: an ack never coincides with a drain because a draining slot is full.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_slot_a  <= '0;
            r_slot_b  <= '0;
            r_full_a  <= 1'b0;
            r_full_b  <= 1'b0;
            r_ack_a_q <= 1'b0;
            r_ack_b_q <= 1'b0;
        end else begin
            r_ack_a_q <= w_ack_a;
            r_ack_b_q <= w_ack_b;
            if (w_ack_a) begin
                r_slot_a <= data_a;
                r_full_a <= 1'b1;
            end else if (w_win_a) begin
                r_full_a <= 1'b0;
            end
            if (w_ack_b) begin
                r_slot_b <= data_b;
                r_full_b <= 1'b1;
            end else if (w_win_b) begin
                r_full_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ST_IDLE;
            r_code   <= '0;
            r_src    <= 2'b00;
            r_idle   <= '0;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_src    <= w_src_nxt;
            r_idle   <= w_idle_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_src_nxt    = r_src;
        w_idle_nxt   = r_idle;
        w_starve_nxt = r_starve;

        if (r_state == ST_LOAD) begin
            w_state_nxt = ST_HOLD;
        end

        if (r_tick) begin
            if (!r_full_b || w_win_b) begin
                w_starve_nxt = '0;
            end else if (r_starve != LP_STARVE_MAX) begin
                w_starve_nxt = r_starve + 1'b1;
            end

            if (w_win_a || w_win_b) begin
                w_code_nxt  = mute ? 4'd0 : (w_win_a ? r_slot_a : r_slot_b);
                w_src_nxt   = w_win_a ? 2'b01 : 2'b10;
                w_idle_nxt  = '0;
                w_state_nxt = ST_LOAD;
            end else begin
                w_idle_nxt = w_idle_inc;
                if (mute) begin
                    w_code_nxt  = 4'd0;
                    w_src_nxt   = 2'b00;
                    w_state_nxt = ST_IDLE;
                end else if (r_state == ST_DECAY || w_idle_inc == LP_IDLE_MAX) begin
                    // Decay steps on the same tick the idle count saturates.
                    w_src_nxt = 2'b00;
                    if (r_code > 4'd1) begin
                        w_code_nxt  = r_code - 4'd1;
                        w_state_nxt = ST_DECAY;
                    end else begin
                        w_code_nxt  = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Randomised and directed stimulus for dac_sample_sched, checked cycle by cycle against a
// frame-level reference model of the scheduling rules.
module tb_dac_sample_sched;

    localparam int FL = 16;
    localparam int SM = 2;
    localparam int IF = 2;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       req_a, req_b, mute;
    logic [3:0] data_a, data_b;
    logic       ack_a, ack_b, frame_tick;
    logic [3:0] dac_code;
    logic [1:0] src_sel;

    dac_sample_sched #(.FRAME_LEN(FL), .STARVE_MAX(SM), .IDLE_FRAMES(IF)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .mute(mute), .dac_code(dac_code), .frame_tick(frame_tick), .src_sel(src_sel)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_cnt, m_starve, m_idle;
    bit         m_full [2];
    logic [3:0] m_slot [2];
    bit         m_ackp [2];
    logic [3:0] m_code;
    logic [1:0] m_src;
    bit         e_ack_a, e_ack_b;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_starve = 0; m_idle = 0;
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0; m_slot[i] = '0; m_ackp[i] = 0;
        end
        m_code = '0; m_src = 2'b00;
        e_ack_a = 0; e_ack_b = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack_a"}, 4'(ack_a), 4'd0);
        chk({tag, "_ack_b"}, 4'(ack_b), 4'd0);
        chk({tag, "_tick"}, 4'(frame_tick), 4'd0);
        chk({tag, "_code"}, dac_code, 4'd0);
        chk({tag, "_src"}, 4'(src_sel), 4'd0);
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        bit ea, eb, tick, fa, fb, win_a, win_b;
        @(negedge Clk);
        tick = (m_cnt == FL - 1);
        ea = req_a && !m_full[0] && !m_ackp[0];
        eb = req_b && !m_full[1] && !m_ackp[1];
        chk("ack_a", 4'(ack_a), 4'(ea));
        chk("ack_b", 4'(ack_b), 4'(eb));
        chk("frame_tick", 4'(frame_tick), 4'(tick));
        chk("dac_code", dac_code, m_code);
        chk("src_sel", 4'(src_sel), 4'(m_src));
        if (tick) begin
            fa = m_full[0];
            fb = m_full[1];
            win_b = fb && (!fa || m_starve == SM);
            win_a = fa && !win_b;
            if (!fb || win_b) m_starve = 0;
            else m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            if (win_a || win_b) begin
                m_code = mute ? 4'd0 : (win_a ? m_slot[0] : m_slot[1]);
                m_src  = win_a ? 2'b01 : 2'b10;
                m_idle = 0;
                if (win_a) m_full[0] = 0; else m_full[1] = 0;
            end else begin
                m_idle = (m_idle < IF) ? m_idle + 1 : IF;
                if (mute) begin
                    m_code = 4'd0; m_src = 2'b00;
                end else if (m_idle == IF) begin
                    m_src = 2'b00;
                    if (m_code != 0) m_code = m_code - 4'd1;
                end
            end
        end
        if (ea) begin m_slot[0] = data_a; m_full[0] = 1; end
        if (eb) begin m_slot[1] = data_b; m_full[1] = 1; end
        m_ackp[0] = ea;
        m_ackp[1] = eb;
        m_cnt = (m_cnt + 1) % FL;
        e_ack_a = ea;
        e_ack_b = eb;
        @(posedge Clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_cnt(input int c);
        for (int i = 0; i < FL && m_cnt != c; i++) step();
    endtask

    initial begin
        Reset_n = 1'b0;
        req_a = 0; req_b = 0; mute = 0; data_a = '0; data_b = '0;
        model_reset();
        #1;
        chk_zero("reset");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        // Idle frames: nothing committed, tick every FL clocks
        run(3 * FL);

        // Single A sample at cnt 3, committed at the next tick
        run_to_cnt(3);
        req_a = 1; data_a = 4'd9;
        step();
        req_a = 0;
        run(2 * FL);

        // Both sources saturated: starvation guard lets B through every third frame
        req_a = 1; req_b = 1; data_a = 4'd5; data_b = 4'd5;
        for (int i = 0; i < 9 * FL; i++) begin
            step();
            if (e_ack_a) data_a = 4'($urandom_range(0, 15));
            if (e_ack_b) data_b = 4'($urandom_range(0, 15));
        end
        req_a = 0; req_b = 0;
        run(3 * FL);

        // Hold then decay: A=3, then silence
        req_a = 1; data_a = 4'd3;
        step();
        req_a = 0;
        run(8 * FL);

        // Backpressure: second request waits for the drain, acked the cycle after the tick
        run_to_cnt(4);
        req_a = 1; data_a = 4'd4;
        step();
        data_a = 4'd11;
        for (int i = 0; i < 2 * FL; i++) begin
            step();
            if (e_ack_a) req_a = 0;
        end
        req_a = 0;
        run(2 * FL);

        // Mute with A=7 pending, then a real commit, then reset mid-frame
        run_to_cnt(5);
        req_a = 1; data_a = 4'd7;
        step();
        req_a = 0; mute = 1;
        run(FL + 2);
        mute = 0;
        req_b = 1; data_b = 4'd12;
        step();
        req_b = 0;
        run(FL + 7);
        req_a = 1; data_a = 4'd6;
        Reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(posedge Clk);
        #1;
        req_a = 0;
        Reset_n = 1'b1;
        model_reset();
        run(2 * FL);

        // Random traffic including mute
        for (int i = 0; i < 50 * FL; i++) begin
            step();
            if (!req_a || e_ack_a) begin
                req_a  = ($urandom_range(0, 3) == 0);
                data_a = 4'($urandom_range(0, 15));
            end
            if (!req_b || e_ack_b) begin
                req_b  = ($urandom_range(0, 2) == 0);
                data_b = 4'($urandom_range(0, 15));
            end
            mute = ($urandom_range(0, 7) == 0);
        end
        req_a = 0; req_b = 0; mute = 0;
        run(6 * FL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
